// File: rtl/mc_maindec_if.sv
// mc_maindec_if: opcode/handshake inputs and datapath control outputs of the multicycle main controller
interface mc_maindec_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       trap_ack;
  logic       mem_req;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcwrite;
  logic       branch;
  logic       branch_ne;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       zeroext;
  logic [1:0] pcsrc;
  logic [2:0] aluop;
  logic       instr_done;
  logic       illegal_op;
  modport master (
    input  op, mem_ready, trap_ack,
    output mem_req, memwrite, iord, irwrite, pcwrite, branch, branch_ne, regdst, memtoreg,
           regwrite, alusrca, alusrcb, zeroext, pcsrc, aluop, instr_done, illegal_op
  );
  modport slave (
    output op, mem_ready, trap_ack,
    input  mem_req, memwrite, iord, irwrite, pcwrite, branch, branch_ne, regdst, memtoreg,
           regwrite, alusrca, alusrcb, zeroext, pcsrc, aluop, instr_done, illegal_op
  );
endinterface

// File: rtl/mc_maindec.sv
// mc_maindec: multicycle MIPS-subset main control FSM with memory handshake and illegal-opcode trap
module mc_maindec #(
  parameter bit EXT_OPS         = 1'b1,
  parameter bit HANDSHAKE       = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  mc_maindec_if.master b
);
  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BRANCH  = 4'd8;
  localparam logic [3:0] IMMEX   = 4'd9;
  localparam logic [3:0] IMMWB   = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;
  localparam logic [3:0] TRAP    = 4'd12;
  logic [3:0] st, nx;
  logic       rdy, lw, sw, rt, beq, bne, addi, andi, ori, slti, j, imm, legal;
  logic [2:0] iop;
  logic       mreq, mwr, irw, pcw, br, brne, rw, dn, il;
  assign rdy   = HANDSHAKE ? b.mem_ready : 1'b1;
  assign rt    = b.op == 6'b000000;
  assign lw    = b.op == 6'b100011;
  assign sw    = b.op == 6'b101011;
  assign beq   = b.op == 6'b000100;
  assign j     = b.op == 6'b000010;
  assign addi  = b.op == 6'b001000;
  assign bne   = EXT_OPS && b.op == 6'b000101;
  assign andi  = EXT_OPS && b.op == 6'b001100;
  assign ori   = EXT_OPS && b.op == 6'b001101;
  assign slti  = EXT_OPS && b.op == 6'b001010;
  assign imm   = addi | andi | ori | slti;
  assign legal = rt | lw | sw | beq | bne | imm | j;
  assign iop   = andi ? 3'b011 : ori ? 3'b100 : slti ? 3'b101 : 3'b000;
  // state register; reset parks the machine in FETCH immediately
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st <= FETCH;
    else st <= nx;
  // Moore decode of outputs and next state, with mem_ready/trap_ack gating where the access completes
  always_comb begin
    nx = st;
    mreq = 1'b0;
    mwr = 1'b0;
    irw = 1'b0;
    pcw = 1'b0;
    br = 1'b0;
    brne = 1'b0;
    rw = 1'b0;
    dn = 1'b0;
    il = 1'b0;
    b.iord = 1'b0;
    b.regdst = 1'b0;
    b.memtoreg = 1'b0;
    b.alusrca = 1'b0;
    b.alusrcb = 2'b00;
    b.zeroext = 1'b0;
    b.pcsrc = 2'b00;
    b.aluop = 3'b000;
    case (st)
      FETCH: begin
        mreq = 1'b1;
        b.alusrcb = 2'b01;
        irw = rdy;
        pcw = rdy;
        nx = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        b.alusrcb = 2'b11;
        dn = !legal && !TRAP_ON_ILLEGAL;
        nx = (lw | sw) ? MEMADR : rt ? RTYPEEX : (beq | bne) ? BRANCH : imm ? IMMEX :
             j ? JEX : TRAP_ON_ILLEGAL ? TRAP : FETCH;
      end
      MEMADR: begin
        b.alusrca = 1'b1;
        b.alusrcb = 2'b10;
        nx = lw ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mreq = 1'b1;
        b.iord = 1'b1;
        nx = rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        b.memtoreg = 1'b1;
        rw = 1'b1;
        dn = 1'b1;
        nx = FETCH;
      end
      MEMWR: begin
        mreq = 1'b1;
        b.iord = 1'b1;
        mwr = 1'b1;
        dn = rdy;
        nx = rdy ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        b.alusrca = 1'b1;
        b.aluop = 3'b010;
        nx = RTYPEWB;
      end
      RTYPEWB: begin
        b.regdst = 1'b1;
        rw = 1'b1;
        dn = 1'b1;
        nx = FETCH;
      end
      BRANCH: begin
        b.alusrca = 1'b1;
        b.aluop = 3'b001;
        b.pcsrc = 2'b01;
        br = beq;
        brne = bne;
        dn = 1'b1;
        nx = FETCH;
      end
      IMMEX, IMMWB: begin
        b.alusrca = 1'b1;
        b.alusrcb = 2'b10;
        b.aluop = iop;
        b.zeroext = andi | ori;
        rw = st == IMMWB;
        dn = st == IMMWB;
        nx = st == IMMEX ? IMMWB : FETCH;
      end
      JEX: begin
        b.pcsrc = 2'b10;
        pcw = 1'b1;
        dn = 1'b1;
        nx = FETCH;
      end
      TRAP: begin
        il = 1'b1;
        dn = b.trap_ack;
        nx = b.trap_ack ? FETCH : TRAP;
      end
      default: nx = FETCH;
    endcase
  end
  assign b.mem_req    = reset_n & mreq;
  assign b.memwrite   = reset_n & mwr;
  assign b.irwrite    = reset_n & irw;
  assign b.pcwrite    = reset_n & pcw;
  assign b.branch     = reset_n & br;
  assign b.branch_ne  = reset_n & brne;
  assign b.regwrite   = reset_n & rw;
  assign b.instr_done = reset_n & dn;
  assign b.illegal_op = reset_n & il;
endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: four parameter variants of mc_maindec checked every cycle against a step-based instruction model
module tb_mc_maindec;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mem_ready = 1'b1;
  logic trap_ack = 1'b0;
  always #5 clk = ~clk;
  localparam bit [3:0] EXT = 4'b1101;
  localparam bit [3:0] HS  = 4'b0111;
  localparam bit [3:0] TR  = 4'b1011;
  localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         J = 6'b000010, ADDI = 6'b001000, BNE = 6'b000101, ANDI = 6'b001100,
                         ORI = 6'b001101, SLTI = 6'b001010;
  logic [5:0]  op [4];
  logic [20:0] outv [4];
  int step [4];
  int nstep [4];
  int ncmp = 0;
  int nfail = 0;
  for (genvar g = 0; g < 4; g++) begin : u
    mc_maindec_if bus();
    mc_maindec #(.EXT_OPS(EXT[g]), .HANDSHAKE(HS[g]), .TRAP_ON_ILLEGAL(TR[g])) dut (
      .clk(clk), .reset_n(reset_n), .b(bus));
    assign bus.op = op[g];
    assign bus.mem_ready = mem_ready;
    assign bus.trap_ack = trap_ack;
    assign outv[g] = {bus.mem_req, bus.memwrite, bus.iord, bus.irwrite, bus.pcwrite, bus.branch,
                      bus.branch_ne, bus.regdst, bus.memtoreg, bus.regwrite, bus.alusrca,
                      bus.alusrcb, bus.zeroext, bus.pcsrc, bus.aluop, bus.instr_done, bus.illegal_op};
  end

  // s counts the cycles of the current instruction ignoring wait cycles: 0 fetch, 1 decode, 2.. execution
  function automatic void model(input bit ext, hs, tr, input logic [5:0] o, input int s,
                                input bit mr, ack, rn, output logic [20:0] e, output int ns);
    bit rdy = !hs || mr;
    bit lw = o == LW, sw = o == SW, rt = o == RTYPE, beq = o == BEQ, j = o == J, addi = o == ADDI;
    bit bne = ext && o == BNE, andi = ext && o == ANDI, ori = ext && o == ORI, slti = ext && o == SLTI;
    bit imm = addi || andi || ori || slti;
    bit ill = !(lw || sw || rt || beq || bne || imm || j);
    logic [2:0] iop = andi ? 3'b011 : ori ? 3'b100 : slti ? 3'b101 : 3'b000;
    bit mreq = 0, mw = 0, iord = 0, irw = 0, pcw = 0, br = 0, brne = 0, rd = 0, m2r = 0, rw = 0;
    bit asa = 0, zx = 0, dn = 0, il = 0;
    logic [1:0] asb = 2'b00, pcs = 2'b00;
    logic [2:0] aop = 3'b000;
    ns = s + 1;
    if (!rn) begin asb = 2'b01; ns = 0; end
    else if (s == 0) begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; ns = rdy ? 1 : 0; end
    else if (s == 1) begin asb = 2'b11; if (ill && !tr) begin dn = 1; ns = 0; end end
    else if (ill) begin il = 1; dn = ack; ns = ack ? 0 : 2; end
    else if (beq || bne) begin asa = 1; aop = 3'b001; pcs = 2'b01; dn = 1; br = beq; brne = bne; ns = 0; end
    else if (j) begin pcs = 2'b10; pcw = 1; dn = 1; ns = 0; end
    else if (s == 2) begin
      asa = 1; asb = rt ? 2'b00 : 2'b10; aop = rt ? 3'b010 : imm ? iop : 3'b000; zx = andi || ori;
    end
    else if (rt) begin rd = 1; rw = 1; dn = 1; ns = 0; end
    else if (imm) begin asa = 1; asb = 2'b10; aop = iop; zx = andi || ori; rw = 1; dn = 1; ns = 0; end
    else if (s == 3) begin mreq = 1; iord = 1; mw = sw; dn = sw && rdy; ns = !rdy ? 3 : sw ? 0 : 4; end
    else begin m2r = 1; rw = 1; dn = 1; ns = 0; end
    e = {mreq, mw, iord, irw, pcw, br, brne, rd, m2r, rw, asa, asb, zx, pcs, aop, dn, il};
  endfunction

  always @(negedge clk) begin
    logic [20:0] e;
    int ns;
    for (int k = 0; k < 4; k++) begin
      model(EXT[k], HS[k], TR[k], op[k], step[k], mem_ready, trap_ack, reset_n, e, ns);
      ncmp++;
      if (outv[k] !== e) begin
        nfail++;
        $display("FAIL outputs dut%0d t=%0t step=%0d op=%b got=%h want=%h", k, $time, step[k], op[k], outv[k], e);
      end
      nstep[k] = ns;
    end
  end

  always @(posedge clk or negedge reset_n)
    for (int k = 0; k < 4; k++) step[k] <= reset_n ? nstep[k] : 0;

  task automatic chk(input string n, input int got, input int exp);
    ncmp++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s got=%0d want=%0d", n, got, exp);
    end
  endtask

  int cyc, irw, mwc, ill, bwe, bnec, zc, il1, il2, dn2;
  logic [20:0] lastv;

  // entered at posedge+1 of a DUT0 fetch cycle; returns at posedge+1 of the next fetch cycle
  task automatic run(input logic [5:0] o, input int fw0, input int mw0, input int ackd);
    int fw = fw0, mw = mw0, ic = 0;
    bit done = 0;
    op[0] = o;
    cyc = 0; irw = 0; mwc = 0; ill = 0; bwe = 0; bnec = 0; zc = 0;
    while (!done && cyc < 60) begin
      mem_ready = 1'b1;
      if (u[0].bus.mem_req && !u[0].bus.iord && fw > 0) begin mem_ready = 1'b0; fw--; end
      else if (u[0].bus.mem_req && u[0].bus.iord && mw > 0) begin mem_ready = 1'b0; mw--; end
      trap_ack = u[0].bus.illegal_op && ic == ackd - 1;
      if (u[0].bus.illegal_op) ic++;
      @(negedge clk);
      cyc++;
      irw += int'(u[0].bus.irwrite);
      mwc += int'(u[0].bus.memwrite);
      ill += int'(u[0].bus.illegal_op);
      bwe += int'(u[0].bus.illegal_op && (u[0].bus.memwrite || u[0].bus.regwrite || u[0].bus.pcwrite ||
                  u[0].bus.irwrite || u[0].bus.branch || u[0].bus.branch_ne || u[0].bus.mem_req));
      bnec += int'(u[0].bus.branch_ne && u[0].bus.aluop == 3'b001);
      zc += int'(u[0].bus.zeroext && u[0].bus.aluop == 3'b100 && u[0].bus.regwrite);
      il1 += int'(u[1].bus.illegal_op);
      il2 += int'(u[2].bus.illegal_op);
      dn2 += int'(u[2].bus.instr_done);
      done = u[0].bus.instr_done;
      lastv = outv[0];
      @(posedge clk);
      #1;
    end
    if (!done) chk("instr_timeout", 0, 1);
  endtask

  function automatic logic [5:0] rop();
    logic [5:0] tbl [10] = '{RTYPE, LW, SW, BEQ, J, ADDI, BNE, ANDI, ORI, SLTI};
    int r = int'($urandom_range(0, 12));
    return r < 10 ? tbl[r] : 6'($urandom);
  endfunction

  initial begin
    for (int k = 0; k < 4; k++) op[k] = RTYPE;
    il1 = 0; il2 = 0; dn2 = 0;
    #2;
    chk("rst_mem_req", int'(u[0].bus.mem_req), 0);
    chk("rst_irwrite", int'(u[0].bus.irwrite), 0);
    chk("rst_alusrcb", int'(u[0].bus.alusrcb), 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    op[1] = BNE; op[2] = 6'b111111; op[3] = LW;
    run(RTYPE, 0, 0, 0);
    chk("rtype_cycles", cyc, 4);
    chk("rtype_wb_regwrite_regdst", int'(lastv[11] && lastv[13]), 1);
    run(LW, 2, 3, 0);
    chk("lw_cycles", cyc, 10);
    chk("lw_irwrite_cycles", irw, 1);
    chk("lw_wb_memtoreg_regwrite", int'(lastv[12] && lastv[11]), 1);
    run(SW, 0, 1, 0);
    chk("sw_cycles", cyc, 5);
    chk("sw_memwrite_cycles", mwc, 2);
    chk("sw_done_with_memwrite", int'(lastv[19] && lastv[1]), 1);
    run(BNE, 0, 0, 0);
    chk("bne_cycles", cyc, 3);
    chk("bne_branch_ne_sub", bnec, 1);
    run(ORI, 0, 0, 0);
    chk("ori_cycles", cyc, 4);
    chk("ori_zeroext_or_regwrite", zc, 1);
    run(J, 0, 0, 0);
    chk("j_cycles", cyc, 3);
    run(6'b111111, 0, 0, 4);
    chk("trap_cycles", cyc, 6);
    chk("trap_illegal_cycles", ill, 4);
    chk("trap_write_enables", bwe, 0);
    chk("noext_bne_traps", int'(il1 > 0), 1);
    chk("notrap_illegal_seen", il2, 0);
    chk("notrap_done_pulses", int'(dn2 > 0), 1);
    op[0] = SW; mem_ready = 1'b1; trap_ack = 1'b0;
    for (int i = 0; i < 8 && !u[0].bus.memwrite; i++) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("memwr_waiting", int'(u[0].bus.memwrite), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_memwrite", int'(u[0].bus.memwrite), 0);
    chk("async_rst_mem_req", int'(u[0].bus.mem_req), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_fetch_req", int'(u[0].bus.mem_req), 1);
    chk("post_rst_fetch_iord", int'(u[0].bus.iord), 0);
    @(posedge clk);
    #1;
    repeat (3000) begin
      for (int k = 0; k < 4; k++) if (step[k] == 0) op[k] = rop();
      mem_ready = $urandom_range(0, 3) != 0;
      trap_ack = $urandom_range(0, 3) == 0;
      reset_n = $urandom_range(0, 199) != 0;
      @(posedge clk);
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/mc_maindec.md
# mc_maindec

Multicycle main control FSM for the MIPS-subset core, replacing the single-cycle main decoder once the datapath is shared across cycles. The block sequences each instruction through fetch, decode, execute, memory and writeback states. It adds a memory ready handshake, optional extended opcodes (BNE, ANDI, ORI, SLTI), and an illegal-opcode trap. It sits between the instruction register's opcode field and the multicycle datapath and memory port.

## Interface
- EXT_OPS, 1: 1 enables BNE, ANDI, ORI and SLTI. 0 makes those opcodes illegal.
- HANDSHAKE, 1: 1 honours mem_ready. 0 treats every memory access as single-cycle, and mem_ready is ignored.
- TRAP_ON_ILLEGAL, 1: 1 sends illegal opcodes to the TRAP state. 0 treats them as NOP (DECODE -> FETCH).
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- op  in  6  opcode from the instruction register; stable after FETCH
- mem_ready  in  1  memory completes the current access this cycle
- trap_ack  in  1  exits TRAP
- mem_req  out  1  memory access request
- memwrite  out  1  memory write enable
- iord  out  1  0 = PC address, 1 = ALUOut address
- irwrite  out  1  instruction register load
- pcwrite  out  1  unconditional PC write
- branch  out  1  PC write if zero
- branch_ne  out  1  PC write if not zero
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = data register, 0 = ALUOut
- regwrite  out  1  register file write
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
- zeroext  out  1  immediate is zero-extended
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- aluop  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
- instr_done  out  1  last cycle of an instruction
- illegal_op  out  1  in TRAP

## Operation
- Opcodes:
  - RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
  - EXT_OPS only: BNE 000101, ANDI 001100, ORI 001101, SLTI 001010.
- Moore FSM. Outputs are decoded from state only, except the mem_ready gating stated below. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00.
  - irwrite=pcwrite=1 only when mem_ready (or HANDSHAKE=0).
  - Stays in FETCH until then, then goes to DECODE.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=000.
  - Next state: LW/SW->MEMADR, RTYPE->RTYPEEX, BEQ/BNE->BRANCH, ADDI/ANDI/ORI/SLTI->IMMEX, J->JEX, otherwise TRAP, or FETCH with instr_done=1 if TRAP_ON_ILLEGAL=0.
- MEMADR:
  - Outputs: alusrca=1, alusrcb=10, aluop=000.
  - Next state: MEMRD for LW, MEMWR for SW.
- MEMRD:
  - Outputs: mem_req=1, iord=1.
  - Holds until mem_ready, then MEMWB.
- MEMWB:
  - Outputs: regdst=0, memtoreg=1, regwrite=1, instr_done=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: mem_req=1, iord=1, memwrite=1; all held while waiting.
  - instr_done=1 on the mem_ready cycle, then FETCH.
- RTYPEEX:
  - Outputs: alusrca=1, alusrcb=00, aluop=010.
  - Next state: RTYPEWB.
- RTYPEWB:
  - Outputs: regdst=1, regwrite=1, instr_done=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: alusrca=1, alusrcb=00, aluop=001, pcsrc=01, instr_done=1.
  - branch=1 for BEQ, branch_ne=1 for BNE.
  - Next state: FETCH.
- IMMEX:
  - Outputs: alusrca=1, alusrcb=10.
  - aluop: 000 for ADDI, 011 for ANDI, 100 for ORI, 101 for SLTI.
  - zeroext=1 for ANDI/ORI.
  - Next state: IMMWB.
- IMMWB:
  - Outputs: regdst=0, memtoreg=0, regwrite=1, instr_done=1.
  - IMMEX mux selects are held.
  - Next state: FETCH.
- JEX:
  - Outputs: pcsrc=10, pcwrite=1, instr_done=1.
  - Next state: FETCH.
- TRAP:
  - Outputs: illegal_op=1, no write enables.
  - Stays until trap_ack, then FETCH with instr_done=1 on the exit cycle.

## Timing
- Reset:
  - While reset_n=0 the state is forced to FETCH.
  - mem_req, memwrite, irwrite, pcwrite, regwrite, branch, branch_ne, instr_done and illegal_op are all forced 0.
  - The remaining outputs carry FETCH values: iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00, regdst=0, memtoreg=0, zeroext=0.
- Reset release:
  - FETCH begins on the first rising edge after release.
  - Reset asserted mid-instruction aborts immediately. No write enable may glitch high.
- Cycle counts with zero memory wait: LW 5, SW 4, RTYPE 4, IMM 4, BRANCH 3, J 3.
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- mem_ready is sampled only in FETCH, MEMRD and MEMWR; it is ignored in every other state.
- trap_ack is sampled only in TRAP.
- instr_done is a single-cycle pulse per instruction.

## Test plan
- Reset, then release with mem_ready=1 and op=000000:
  - Required states: FETCH, DECODE, RTYPEEX, RTYPEWB.
  - regwrite=1 and regdst=1 in cycle 4; instr_done pulses once.
- LW with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD:
  - Required: 10 cycles total.
  - irwrite high only on the FETCH ready cycle; memtoreg=1 and regwrite=1 in MEMWB.
- SW with mem_ready low for 1 MEMWR cycle:
  - Required: memwrite held high for 2 cycles.
  - instr_done coincides with mem_ready.
- BNE and ORI with EXT_OPS=1:
  - BNE gives branch_ne=1 with aluop=001.
  - ORI gives aluop=100, zeroext=1, and regwrite in IMMWB.
  - With EXT_OPS=0 the same opcodes enter TRAP.
- op=111111 with TRAP_ON_ILLEGAL=1:
  - illegal_op stays high for 4 cycles until trap_ack, then FETCH; no write enable is ever asserted.
  - With TRAP_ON_ILLEGAL=0: DECODE goes to FETCH with instr_done=1.
- reset_n dropped during MEMWR while waiting:
  - memwrite and mem_req fall asynchronously.
  - After release, FETCH with PC-addressed fetch.
